// File: rtl/wishbone_arb2_if.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_arb2_if
//  Description : One Wishbone link (cycle/strobe/write enable, address, data,
//                handshake returns). The arbiter uses one instance per master
//                (slave modport) and one for the shared slave (master modport).
//  Revision    : 1.0  initial release
// ============================================================================
interface wishbone_arb2_if #(
    parameter int pAddrWidth = 32,
    parameter int pDataWidth = 32
);
    logic                  Cyc;
    logic                  Stb;
    logic                  WEn;
    logic [pAddrWidth-1:0] Addr;
    logic [pDataWidth-1:0] WrData;
    logic [pDataWidth-1:0] RdData;
    logic                  Ack;
    logic                  Stall;
    logic                  Rty;
    logic                  Err;

    // Initiator side. The shared slave has no error return (errors toward
    // the masters are produced by the arbiter's watchdog), so Err is not
    // part of this view.
    modport master (
        output Cyc, Stb, WEn, Addr, WrData,
        input  RdData, Ack, Stall, Rty
    );

    // Target side, as seen by the arbiter facing each master.
    modport slave (
        input  Cyc, Stb, WEn, Addr, WrData,
        output RdData, Ack, Stall, Rty, Err
    );
endinterface
`default_nettype wire

// File: rtl/wishbone_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_arb2
//  Description : Two-master Wishbone arbiter with round-robin tie break,
//                one-cycle arbitration latency and a per-grant watchdog that
//                aborts a cycle the slave never acknowledges.
//  Revision    : 1.0  initial release
// ============================================================================
module wishbone_arb2 #(
    parameter int pAddrWidth = 32,
    parameter int pDataWidth = 32,
    parameter int pTimeout   = 255   // legal range 2..65535
) (
    input  logic            i_Clk,
    input  logic            i_ARst_L,
    wishbone_arb2_if.slave  M0,
    wishbone_arb2_if.slave  M1,
    wishbone_arb2_if.master Wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(pTimeout);

    state_t          state_q;
    state_t          state_d;
    logic            last_gnt_q;   // master served most recently
    logic            last_gnt_d;
    logic [15:0]     tmo_cnt_q;    // cycles the owner has waited for Ack
    logic [15:0]     tmo_cnt_d;

    logic                  w_own_cyc;
    logic                  w_own_stb;
    logic                  w_own_wen;
    logic [pAddrWidth-1:0] w_own_addr;
    logic [pDataWidth-1:0] w_own_wdata;
    logic                  w_timeout;

    // Select the current owner's request; nothing is selected while idle.
    always_comb begin
        w_own_cyc   = 1'b0;
        w_own_stb   = 1'b0;
        w_own_wen   = 1'b0;
        w_own_addr  = '0;
        w_own_wdata = '0;
        case (state_q)
            GNT0: begin
                w_own_cyc   = M0.Cyc;
                w_own_stb   = M0.Stb;
                w_own_wen   = M0.WEn;
                w_own_addr  = M0.Addr;
                w_own_wdata = M0.WrData;
            end
            GNT1: begin
                w_own_cyc   = M1.Cyc;
                w_own_stb   = M1.Stb;
                w_own_wen   = M1.WEn;
                w_own_addr  = M1.Addr;
                w_own_wdata = M1.WrData;
            end
            default: ;
        endcase
    end

    // Watchdog fires when the wait budget is used up; an Ack arriving in the
    // same cycle still completes the transfer normally.
    assign w_timeout = (state_q != IDLE) && w_own_cyc &&
                       (tmo_cnt_q == c_TIMEOUT) && !Wb.Ack;

    // Next state, tie-break pointer and watchdog counter.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (M0.Cyc && M1.Cyc) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (M0.Cyc) begin
                    state_d = GNT0;
                end else if (M1.Cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!M0.Cyc || w_timeout) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end
            GNT1: begin
                if (!M1.Cyc || w_timeout) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter is held at zero while idle so every grant starts fresh.
        if ((state_q == IDLE) || Wb.Ack) begin
            tmo_cnt_d = '0;
        end else if (w_own_stb && (tmo_cnt_q != c_TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // State registers; reset returns to idle with M0 favoured on the first tie.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Shared slave bus: owner's request, with Cyc/Stb pulled low on abort.
    always_comb begin
        Wb.Cyc    = w_own_cyc & ~w_timeout;
        Wb.Stb    = w_own_stb & ~w_timeout;
        Wb.WEn    = w_own_wen;
        Wb.Addr   = w_own_addr;
        Wb.WrData = w_own_wdata;
    end

    // Returns to M0: slave handshake when owner, otherwise stall while asking.
    always_comb begin
        M0.RdData = Wb.RdData;
        M0.Ack    = 1'b0;
        M0.Rty    = 1'b0;
        M0.Err    = 1'b0;
        M0.Stall  = M0.Cyc;
        if (state_q == GNT0) begin
            M0.Ack   = Wb.Ack;
            M0.Rty   = Wb.Rty;
            M0.Stall = Wb.Stall;
            M0.Err   = w_timeout;
        end
    end

    // Returns to M1: slave handshake when owner, otherwise stall while asking.
    always_comb begin
        M1.RdData = Wb.RdData;
        M1.Ack    = 1'b0;
        M1.Rty    = 1'b0;
        M1.Err    = 1'b0;
        M1.Stall  = M1.Cyc;
        if (state_q == GNT1) begin
            M1.Ack   = Wb.Ack;
            M1.Rty   = Wb.Rty;
            M1.Stall = Wb.Stall;
            M1.Err   = w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_arb2
//  Description : Self-checking bench for wishbone_arb2 (watchdog of 4 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wishbone_arb2;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wishbone_arb2_if #(.pAddrWidth(AW), .pDataWidth(DW)) m0_if ();
    wishbone_arb2_if #(.pAddrWidth(AW), .pDataWidth(DW)) m1_if ();
    wishbone_arb2_if #(.pAddrWidth(AW), .pDataWidth(DW)) wb_if ();

    // Slave ack: manual pulse, or an addressed auto-responder used by the
    // back-to-back scenario (answers the owner whose strobe is up).
    logic          ack_man;
    logic          ack_auto;
    logic [AW-1:0] b2b_a0;
    logic [AW-1:0] b2b_a1;
    assign wb_if.Ack = ack_man |
        (ack_auto & (((wb_if.Addr == b2b_a0) & m0_if.Stb) |
                     ((wb_if.Addr == b2b_a1) & m1_if.Stb)));

    wishbone_arb2 #(.pAddrWidth(AW), .pDataWidth(DW), .pTimeout(TMO)) dut (
        .i_Clk    (clk),
        .i_ARst_L (rst_n),
        .M0       (m0_if),
        .M1       (m1_if),
        .Wb       (wb_if)
    );

    typedef struct packed {
        logic          m;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Scoreboard: every master Ack must match the oldest expected transfer.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic          am;
        logic [DW-1:0] rd;
        if (m0_if.Ack || m1_if.Ack) begin
            n_checks++;
            am = m1_if.Ack;
            rd = am ? m1_if.RdData : m0_if.RdData;
            if (m0_if.Ack && m1_if.Ack) begin
                n_errors++;
                $display("FAIL sb_dual_ack: got m0=1 m1=1, required one ack");
            end else if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_ack: got ack master %0d addr %h, required none", am, wb_if.Addr);
            end else begin
                e = sb_q.pop_front();
                if (am !== e.m || wb_if.Addr !== e.addr || wb_if.WEn !== e.we ||
                    rd !== e.rdata || (e.we && wb_if.WrData !== e.wdata)) begin
                    n_errors++;
                    $display("FAIL sb_xfer: got m%0d a=%h we=%0b wd=%h rd=%h, required m%0d a=%h we=%0b wd=%h rd=%h",
                             am, wb_if.Addr, wb_if.WEn, wb_if.WrData, rd,
                             e.m, e.addr, e.we, e.wdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic m, input logic [AW-1:0] a, input logic we,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t e;
        e.m = m; e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic drv(input logic m, input logic cyc, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
        if (m) begin
            m1_if.Cyc = cyc; m1_if.Stb = cyc; m1_if.WEn = we; m1_if.Addr = a; m1_if.WrData = wd;
        end else begin
            m0_if.Cyc = cyc; m0_if.Stb = cyc; m0_if.WEn = we; m0_if.Addr = a; m0_if.WrData = wd;
        end
    endtask

    task automatic test_reset();
        drv(0, 1'b1, 1'b1, 32'h44, 32'h55);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ack_man = 1'b1;
        #1 rst_n = 1'b0;
        smp();
        n_checks++;
        if ({wb_if.Cyc, wb_if.Stb, wb_if.WEn} !== 3'b000 || wb_if.Addr !== '0 || wb_if.WrData !== '0) begin
            n_errors++;
            $display("FAIL rst_slave_idle: got cyc/stb/we=%b%b%b a=%h wd=%h, required 000 0 0",
                     wb_if.Cyc, wb_if.Stb, wb_if.WEn, wb_if.Addr, wb_if.WrData);
        end
        n_checks++;
        if ({m0_if.Stall, m1_if.Stall, m0_if.Ack, m0_if.Err, m0_if.Rty} !== 5'b10000) begin
            n_errors++;
            $display("FAIL rst_master_ret: got st0 st1 ack0 err0 rty0=%b, required 10000",
                     {m0_if.Stall, m1_if.Stall, m0_if.Ack, m0_if.Err, m0_if.Rty});
        end
        tick();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        ack_man = 1'b0;
        tick();
        rst_n = 1'b1;
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_release_idle: got wbcyc=%b, required 0", wb_if.Cyc);
        end
    endtask

    task automatic test_tie();
        tick();
        drv(0, 1'b1, 1'b1, 32'h100, 32'h1111);
        drv(1, 1'b1, 1'b0, 32'h200, 32'h0);
        smp();
        n_checks++;
        if ({wb_if.Cyc, m0_if.Stall, m1_if.Stall} !== 3'b011) begin
            n_errors++;
            $display("FAIL tie_latency: got wbcyc st0 st1=%b, required 011", {wb_if.Cyc, m0_if.Stall, m1_if.Stall});
        end
        tick();
        ack_man = 1'b1;
        push(1'b0, 32'h100, 1'b1, 32'h1111, 32'h0);
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b1 || wb_if.Addr !== 32'h100 || m1_if.Stall !== 1'b1) begin
            n_errors++;
            $display("FAIL tie_gnt0: got wbcyc=%b a=%h st1=%b, required 1 100 1", wb_if.Cyc, wb_if.Addr, m1_if.Stall);
        end
        tick();
        ack_man = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h100, 32'h0);
        smp();
        tick();
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b0 || m1_if.Stall !== 1'b1) begin
            n_errors++;
            $display("FAIL tie_idle_gap: got wbcyc=%b st1=%b, required 0 1", wb_if.Cyc, m1_if.Stall);
        end
        tick();
        ack_man = 1'b1;
        push(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b1 || wb_if.Addr !== 32'h200 || m1_if.Stall !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_gnt1: got wbcyc=%b a=%h st1=%b, required 1 200 0", wb_if.Cyc, wb_if.Addr, m1_if.Stall);
        end
        tick();
        ack_man = 1'b0;
        drv(1, 1'b0, 1'b0, 32'h200, 32'h0);
        tick();
    endtask

    task automatic test_write();
        tick();
        drv(0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
        smp();
        tick();
        smp();
        n_checks++;
        if ({wb_if.Cyc, wb_if.Stb, wb_if.WEn} !== 3'b111 || wb_if.Addr !== 32'h10 ||
            wb_if.WrData !== 32'hA5A5A5A5 || m0_if.Ack !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_bus: got cyc/stb/we=%b%b%b a=%h wd=%h ack0=%b, required 111 10 a5a5a5a5 0",
                     wb_if.Cyc, wb_if.Stb, wb_if.WEn, wb_if.Addr, wb_if.WrData, m0_if.Ack);
        end
        tick();
        wb_if.Rty = 1'b1;
        smp();
        n_checks++;
        if ({m0_if.Rty, m1_if.Rty, m0_if.Ack} !== 3'b100) begin
            n_errors++;
            $display("FAIL wr_rty_fwd: got rty0 rty1 ack0=%b, required 100", {m0_if.Rty, m1_if.Rty, m0_if.Ack});
        end
        tick();
        wb_if.Rty = 1'b0;
        ack_man = 1'b1;
        push(1'b0, 32'h10, 1'b1, 32'hA5A5A5A5, 32'h0);
        smp();
        n_checks++;
        if ({m0_if.Ack, m1_if.Ack} !== 2'b10) begin
            n_errors++;
            $display("FAIL wr_ack3: got ack0 ack1=%b, required 10", {m0_if.Ack, m1_if.Ack});
        end
        tick();
        ack_man = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h10, 32'h0);
        smp();
        n_checks++;
        if (m0_if.Ack !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_ack_once: got ack0=%b, required 0", m0_if.Ack);
        end
        tick();
    endtask

    task automatic test_read();
        tick();
        drv(1, 1'b1, 1'b0, 32'h20, 32'h0);
        smp();
        tick();
        wb_if.Stall = 1'b1;
        smp();
        n_checks++;
        if ({m1_if.Stall, m0_if.Stall, wb_if.WEn} !== 3'b100) begin
            n_errors++;
            $display("FAIL rd_stall_fwd: got st1 st0 we=%b, required 100", {m1_if.Stall, m0_if.Stall, wb_if.WEn});
        end
        tick();
        wb_if.Stall  = 1'b0;
        wb_if.RdData = 32'h12345678;
        ack_man = 1'b1;
        push(1'b1, 32'h20, 1'b0, 32'h0, 32'h12345678);
        smp();
        n_checks++;
        if (m1_if.Ack !== 1'b1 || m1_if.RdData !== 32'h12345678 || m0_if.RdData !== 32'h12345678 || m0_if.Ack !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_data: got ack1=%b rd1=%h rd0=%h ack0=%b, required 1 12345678 12345678 0",
                     m1_if.Ack, m1_if.RdData, m0_if.RdData, m0_if.Ack);
        end
        tick();
        ack_man = 1'b0;
        wb_if.RdData = 32'h0;
        drv(1, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        tick();
        drv(0, 1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        for (int i = 1; i <= TMO; i++) begin
            smp();
            n_checks++;
            if (m0_if.Err !== 1'b0 || wb_if.Cyc !== 1'b1) begin
                n_errors++;
                $display("FAIL tmo_wait_%0d: got err0=%b wbcyc=%b, required 0 1", i, m0_if.Err, wb_if.Cyc);
            end
            tick();
        end
        drv(1, 1'b1, 1'b0, 32'h40, 32'h0);
        smp();
        n_checks++;
        if ({m0_if.Err, wb_if.Cyc, wb_if.Stb, m1_if.Stall} !== 4'b1001) begin
            n_errors++;
            $display("FAIL tmo_abort: got err0 wbcyc wbstb st1=%b, required 1001", {m0_if.Err, wb_if.Cyc, wb_if.Stb, m1_if.Stall});
        end
        tick();
        smp();
        n_checks++;
        if ({m0_if.Err, wb_if.Cyc, m0_if.Stall} !== 3'b001) begin
            n_errors++;
            $display("FAIL tmo_idle: got err0 wbcyc st0=%b, required 001", {m0_if.Err, wb_if.Cyc, m0_if.Stall});
        end
        tick();
        ack_man = 1'b1;
        push(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        smp();
        n_checks++;
        if (wb_if.Addr !== 32'h40 || m0_if.Stall !== 1'b1) begin
            n_errors++;
            $display("FAIL tmo_rearb: got a=%h st0=%b, required 40 1", wb_if.Addr, m0_if.Stall);
        end
        tick();
        ack_man = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_ack_timeout();
        tick();
        drv(0, 1'b1, 1'b0, 32'h50, 32'h0);
        tick();
        for (int i = 1; i <= TMO; i++) begin
            smp();
            tick();
        end
        ack_man = 1'b1;
        push(1'b0, 32'h50, 1'b0, 32'h0, 32'h0);
        smp();
        n_checks++;
        if ({m0_if.Err, wb_if.Cyc, m0_if.Ack} !== 3'b011) begin
            n_errors++;
            $display("FAIL ackto_same: got err0 wbcyc ack0=%b, required 011", {m0_if.Err, wb_if.Cyc, m0_if.Ack});
        end
        tick();
        ack_man = 1'b0;
        smp();
        n_checks++;
        if ({m0_if.Err, wb_if.Cyc} !== 2'b01) begin
            n_errors++;
            $display("FAIL ackto_cleared: got err0 wbcyc=%b, required 01", {m0_if.Err, wb_if.Cyc});
        end
        tick();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_drop_ack();
        tick();
        drv(1, 1'b1, 1'b0, 32'h60, 32'h0);
        tick();
        tick();
        m1_if.Cyc = 1'b0;
        m1_if.Stb = 1'b0;
        ack_man = 1'b1;
        push(1'b1, 32'h60, 1'b0, 32'h0, 32'h0);
        smp();
        n_checks++;
        if ({m1_if.Ack, wb_if.Cyc} !== 2'b10) begin
            n_errors++;
            $display("FAIL drop_ack_fwd: got ack1 wbcyc=%b, required 10", {m1_if.Ack, wb_if.Cyc});
        end
        tick();
        ack_man = 1'b0;
        smp();
        n_checks++;
        if ({m1_if.Ack, wb_if.Cyc} !== 2'b00) begin
            n_errors++;
            $display("FAIL drop_ack_idle: got ack1 wbcyc=%b, required 00", {m1_if.Ack, wb_if.Cyc});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   rem0 = 3;
        int   rem1 = 3;
        logic saw0 = 1'b0;
        logic saw1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, b2b_a0, 1'b0, 32'h0, 32'h0);
            push(1'b1, b2b_a1, 1'b0, 32'h0, 32'h0);
        end
        drv(0, 1'b0, 1'b0, b2b_a0, 32'h0);
        drv(1, 1'b0, 1'b0, b2b_a1, 32'h0);
        ack_auto = 1'b1;
        for (int c = 0; c < 80 && (rem0 > 0 || rem1 > 0 || m0_if.Cyc || m1_if.Cyc); c++) begin
            tick();
            if (m0_if.Cyc && saw0) begin
                m0_if.Cyc = 1'b0; m0_if.Stb = 1'b0; rem0--;
            end else if (!m0_if.Cyc && rem0 > 0) begin
                m0_if.Cyc = 1'b1; m0_if.Stb = 1'b1;
            end
            if (m1_if.Cyc && saw1) begin
                m1_if.Cyc = 1'b0; m1_if.Stb = 1'b0; rem1--;
            end else if (!m1_if.Cyc && rem1 > 0) begin
                m1_if.Cyc = 1'b1; m1_if.Stb = 1'b1;
            end
            smp();
            saw0 = m0_if.Ack;
            saw1 = m1_if.Ack;
        end
        n_checks++;
        if (rem0 != 0 || rem1 != 0 || sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_done: got rem0=%0d rem1=%0d pending=%0d, required 0 0 0", rem0, rem1, sb_q.size());
            sb_q.delete();
        end
        ack_auto = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        drv(0, 1'b1, 1'b0, 32'h90, 32'h0);
        tick();
        ack_man = 1'b1;
        push(1'b0, 32'h90, 1'b0, 32'h0, 32'h0);
        smp();
        tick();
        ack_man = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h90, 32'h0);
        tick();
        drv(1, 1'b1, 1'b0, 32'hA0, 32'h0);
        tick();
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b1 || wb_if.Addr !== 32'hA0) begin
            n_errors++;
            $display("FAIL rmid_gnt1: got wbcyc=%b a=%h, required 1 a0", wb_if.Cyc, wb_if.Addr);
        end
        #2;
        ack_man = 1'b1;
        rst_n   = 1'b0;
        #1;
        n_checks++;
        if ({wb_if.Cyc, wb_if.Stb, m1_if.Ack} !== 3'b000) begin
            n_errors++;
            $display("FAIL rmid_async: got wbcyc wbstb ack1=%b, required 000", {wb_if.Cyc, wb_if.Stb, m1_if.Ack});
        end
        drv(0, 1'b1, 1'b0, 32'h90, 32'h0);
        tick();
        n_checks++;
        if ({wb_if.Cyc, m0_if.Ack, m1_if.Ack, m0_if.Stall, m1_if.Stall} !== 5'b00011) begin
            n_errors++;
            $display("FAIL rmid_held: got wbcyc ack0 ack1 st0 st1=%b, required 00011",
                     {wb_if.Cyc, m0_if.Ack, m1_if.Ack, m0_if.Stall, m1_if.Stall});
        end
        ack_man = 1'b0;
        rst_n   = 1'b1;
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_release: got wbcyc=%b, required 0", wb_if.Cyc);
        end
        tick();
        smp();
        n_checks++;
        if (wb_if.Cyc !== 1'b1 || wb_if.Addr !== 32'h90 || m1_if.Stall !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_tie_m0: got wbcyc=%b a=%h st1=%b, required 1 90 1", wb_if.Cyc, wb_if.Addr, m1_if.Stall);
        end
        tick();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        ack_man = 1'b0;
        ack_auto = 1'b0;
        b2b_a0 = 32'h70;
        b2b_a1 = 32'h80;
        wb_if.Stall  = 1'b0;
        wb_if.Rty    = 1'b0;
        wb_if.RdData = 32'h0;
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);

        test_reset();
        test_tie();
        test_write();
        test_read();
        test_timeout();
        test_ack_timeout();
        test_drop_ack();
        test_back_to_back();
        test_reset_mid();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, required finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
`default_nettype wire
